// File: rtl/softmax_pkg.sv
// ------------------------------------------------------------------
// softmax_pkg: shared state and pass encodings for the softmax scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    localparam logic [1:0] PASS_MAX    = 2'd0;
    localparam logic [1:0] PASS_EXPSUM = 2'd1;
    localparam logic [1:0] PASS_NORM   = 2'd2;

    localparam int DRAIN_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/softmax_range_counter.sv
// ------------------------------------------------------------------
// softmax_range_counter: loadable up-counter that stops at last_val
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module softmax_range_counter
    import softmax_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic [WIDTH-1:0] last_val,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Equality test keeps the top-of-range address safe from wrap
    assign terminal = (count_q == last_val);
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && !terminal) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/softmax_pass_sched.sv
// ------------------------------------------------------------------
// softmax_pass_sched: issues MAX/EXPSUM/NORM address passes with drain gaps
// Macro SOFTMAX_SCHED_PERF_EN adds the busy-cycle counter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module softmax_pass_sched
    import softmax_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DRAIN  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic [1:0]        pass,
    output logic              pass_first,
    output logic              pass_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycle_count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(1);

    state_e                  state_q, state_d;
    logic [1:0]              pass_q, pass_d;
    logic [ADDR_W-1:0]       start_addr_q, start_addr_d;
    logic [ADDR_W-1:0]       end_addr_q, end_addr_d;
    logic [DRAIN_CNT_W-1:0]  drain_q, drain_d;
    logic                    err_q, err_d;

    logic                    cnt_load;
    logic                    cnt_en;
    logic                    cnt_term;
    logic [ADDR_W-1:0]       cnt_load_val;
    logic [ADDR_W-1:0]       cnt_value;
    logic                    run_beat;

    softmax_range_counter #(
        .WIDTH (ADDR_W)
    ) u_addr_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (init),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .enable   (cnt_en),
        .last_val (end_addr_q),
        .count    (cnt_value),
        .terminal (cnt_term)
    );

    assign run_beat   = (state_q == ST_RUN) && !stall;
    assign addr       = cnt_value;
    assign addr_valid = run_beat;
    assign pass       = pass_q;
    assign pass_first = run_beat && (cnt_value == start_addr_q);
    assign pass_last  = run_beat && cnt_term;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign err        = done && err_q;

    always_comb begin
        state_d      = state_q;
        pass_d       = pass_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        drain_d      = drain_q;
        err_d        = err_q;
        cnt_load     = 1'b0;
        cnt_load_val = start_addr_q;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (end_addr >= start_addr) begin
                        start_addr_d = start_addr;
                        end_addr_d   = end_addr;
                        pass_d       = PASS_MAX;
                        cnt_load     = 1'b1;
                        cnt_load_val = start_addr;
                        err_d        = 1'b0;
                        state_d      = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (cnt_term) begin
                        drain_d = DRAIN_LOAD;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Stall is deliberately ignored so the drain window is fixed
                if (drain_q == DRAIN_LAST) begin
                    if (pass_q != PASS_NORM) begin
                        pass_d   = pass_q + 2'd1;
                        cnt_load = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    drain_d = drain_q - DRAIN_LAST;
                end
            end
            ST_FIN: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || init) begin
            state_q      <= ST_IDLE;
            pass_q       <= PASS_MAX;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            drain_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pass_q       <= pass_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            drain_q      <= drain_d;
            err_q        <= err_d;
        end
    end

`ifdef SOFTMAX_SCHED_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        start_accept;

    assign start_accept = (state_q == ST_IDLE) && start;
    assign cycle_count  = cycle_count_q;

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (start_accept) begin
            cycle_count_d = '0;
        end else if (busy && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || init) begin
            cycle_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmax_pass_sched.sv
// ------------------------------------------------------------------
// tb_softmax_pass_sched: directed and randomized jobs against a timeline model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_softmax_pass_sched;

    localparam int AW   = 10;
    localparam int DR   = 4;
    localparam int MAXT = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          stall;
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic [1:0]    pass;
    logic          pass_first;
    logic          pass_last;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   cycle_count;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle timeline of one job, cycle 0 = start sampled
    bit            stall_arr [MAXT];
    bit            e_valid   [MAXT];
    bit            e_first   [MAXT];
    bit            e_last    [MAXT];
    bit            e_addr_chk[MAXT];
    bit            e_pass_chk[MAXT];
    logic [AW-1:0] e_addr    [MAXT];
    logic [1:0]    e_pass    [MAXT];
    int            done_t;
    bit            err_exp;

    softmax_pass_sched #(
        .ADDR_W (AW),
        .DRAIN  (DR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .start       (start),
        .start_addr  (start_addr),
        .end_addr    (end_addr),
        .stall       (stall),
        .addr        (addr),
        .addr_valid  (addr_valid),
        .pass        (pass),
        .pass_first  (pass_first),
        .pass_last   (pass_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Walk passes and addresses in order; a stalled cycle delays the beat
    task automatic build(input int s, input int e);
        int t;
        for (int i = 0; i < MAXT; i++) begin
            e_valid[i] = 0; e_first[i] = 0; e_last[i] = 0;
            e_addr_chk[i] = 0; e_pass_chk[i] = 0;
            e_addr[i] = '0; e_pass[i] = '0;
        end
        if (e < s) begin
            done_t  = 1;
            err_exp = 1'b1;
            return;
        end
        err_exp = 1'b0;
        t = 1;
        for (int p = 0; p < 3; p++) begin
            for (int a = s; a <= e; a++) begin
                while (stall_arr[t]) begin
                    e_addr[t] = AW'(a); e_addr_chk[t] = 1;
                    e_pass[t] = 2'(p);  e_pass_chk[t] = 1;
                    t++;
                end
                e_valid[t] = 1;
                e_addr[t]  = AW'(a); e_addr_chk[t] = 1;
                e_pass[t]  = 2'(p);  e_pass_chk[t] = 1;
                e_first[t] = (a == s);
                e_last[t]  = (a == e);
                t++;
            end
            for (int d = 0; d < DR; d++) begin
                e_pass[t] = 2'(p); e_pass_chk[t] = 1;
                t++;
            end
        end
        done_t = t;
        e_pass[t] = 2'd2; e_pass_chk[t] = 1;
    endtask

    // mode: 0 no stall, 1 stall cycles 11..13, 2 random stall
    task automatic run_job(input int s, input int e, input int mode, input bit spurious);
        for (int i = 0; i < MAXT; i++) stall_arr[i] = 0;
        if (mode == 1) begin
            for (int i = 11; i <= 13; i++) stall_arr[i] = 1;
        end else if (mode == 2) begin
            for (int i = 1; i < 150; i++) stall_arr[i] = ($urandom_range(0, 3) == 0);
        end
        build(s, e);
        start_addr = AW'(s);
        end_addr   = AW'(e);
        stall      = 1'b0;
        start      = 1'b1;
        step();
        for (int t = 1; t <= done_t + 1; t++) begin
            stall = stall_arr[t];
            if (spurious && t <= done_t) begin
                start      = 1'($urandom_range(0, 1));
                start_addr = AW'($urandom_range(0, 1023));
                end_addr   = AW'($urandom_range(0, 1023));
            end else begin
                start = 1'b0;
            end
            #1;
            check1("addr_valid", addr_valid, e_valid[t]);
            check1("pass_first", pass_first, e_first[t]);
            check1("pass_last", pass_last, e_last[t]);
            check1("busy", busy, t <= done_t);
            check1("done", done, t == done_t);
            check1("err", err, (t == done_t) && err_exp);
            if (e_addr_chk[t]) checkw("addr", 32'(addr), 32'(e_addr[t]));
            if (e_pass_chk[t]) checkw("pass", 32'(pass), 32'(e_pass[t]));
`ifdef SOFTMAX_SCHED_PERF_EN
            checkw("cycle_count", cycle_count, 32'(t - 1));
`else
            checkw("cycle_count", cycle_count, 32'd0);
`endif
            if (t <= done_t) step();
        end
        start = 1'b0;
        stall = 1'b0;
        step();
    endtask

    task automatic check_reset_state(input string tag);
        checkw({tag, "_addr"}, 32'(addr), 32'd0);
        check1({tag, "_addr_valid"}, addr_valid, 1'b0);
        checkw({tag, "_pass"}, 32'(pass), 32'd0);
        check1({tag, "_pass_first"}, pass_first, 1'b0);
        check1({tag, "_pass_last"}, pass_last, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        checkw({tag, "_cycle_count"}, cycle_count, 32'd0);
    endtask

    // Start a 0..3 job and kill it with reset or init during abort_t
    task automatic abort_job(input bit use_init, input int abort_t);
        start_addr = AW'(0);
        end_addr   = AW'(3);
        stall      = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < abort_t; t++) step();
        if (use_init) init = 1'b1;
        else          reset = 1'b0;
        step();
        reset = 1'b1;
        init  = 1'b0;
        check_reset_state(use_init ? "abort_init" : "abort_reset");
    endtask

    initial begin
        reset      = 1'b0;
        init       = 1'b0;
        start      = 1'b1;
        stall      = 1'b0;
        start_addr = '0;
        end_addr   = AW'(3);
        step();
        step();
        check_reset_state("por");
        start = 1'b0;
        reset = 1'b1;
        step();

        run_job(0, 3, 0, 1'b0);
        run_job(5, 5, 0, 1'b0);
        run_job(8, 3, 0, 1'b0);
        run_job(0, 3, 1, 1'b0);

        abort_job(1'b0, 14);
        run_job(0, 3, 0, 1'b0);
        abort_job(1'b1, 3);
        run_job(5, 5, 0, 1'b0);

        run_job(1020, 1023, 2, 1'b1);
        run_job(1023, 1023, 0, 1'b0);
        run_job(1023, 1022, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            int s, e;
            s = int'($urandom_range(0, 1018));
            if ($urandom_range(0, 5) == 0 && s > 0) e = s - 1 - int'($urandom_range(0, 0));
            else                                      e = s + int'($urandom_range(0, 5));
            run_job(s, e, 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
